// File: rtl/xor_checksum_accum.sv
// ============================================================================
// Module      : xor_checksum_accum
// Description : XOR-folds a framed stream of WIDTH-bit words and returns
//               {checksum, parity} on a valid/ready result port.
//               Optional macro XOR_ACC_BEAT_COUNT_EN adds an out_beats port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module xor_checksum_accum #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_checksum,
    output logic             out_parity
`ifdef XOR_ACC_BEAT_COUNT_EN
    ,
    output logic [CNT_W-1:0] out_beats
`endif
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ACCUM = 2'd1;
    localparam logic [1:0] c_ST_DONE  = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_checksum;
    logic             r_parity;
    logic [WIDTH-1:0] w_fold;
    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_beat;
    logic             w_result_taken;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Handshake flags come from state alone, so no input reaches an output.
    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            c_ST_IDLE, c_ST_ACCUM: begin
                w_in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = in_last ? c_ST_DONE : c_ST_ACCUM;
                end
            end
            c_ST_DONE: begin
                w_out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    assign in_ready       = w_in_ready;
    assign out_valid      = w_out_valid;
    assign w_beat         = in_valid & w_in_ready;
    assign w_result_taken = (r_state == c_ST_DONE) & out_ready;
    // The first beat of a frame seeds the fold rather than XORing stale state.
    assign w_fold         = (r_state == c_ST_ACCUM) ? (r_acc ^ in_data) : in_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc      <= '0;
            r_checksum <= '0;
            r_parity   <= 1'b0;
        end else begin
            if (w_beat) begin
                if (in_last) begin
                    r_checksum <= w_fold;
                    r_parity   <= ^w_fold;
                end else begin
                    r_acc <= w_fold;
                end
            end
            if (w_result_taken) begin
                r_acc <= '0;
            end
        end
    end

    assign out_checksum = r_checksum;
    assign out_parity   = r_parity;

`ifdef XOR_ACC_BEAT_COUNT_EN
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_beat_cnt;
    logic [CNT_W-1:0] r_out_beats;
    logic [CNT_W-1:0] w_cnt_nxt;

    // Saturate rather than wrap so an oversized frame never reports a small count.
    assign w_cnt_nxt = (r_state == c_ST_IDLE) ? c_CNT_ONE :
                       (&r_beat_cnt)           ? r_beat_cnt :
                                                 (r_beat_cnt + c_CNT_ONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat_cnt  <= '0;
            r_out_beats <= '0;
        end else begin
            if (w_beat) begin
                r_beat_cnt <= w_cnt_nxt;
                if (in_last) begin
                    r_out_beats <= w_cnt_nxt;
                end
            end
            if (w_result_taken) begin
                r_beat_cnt <= '0;
            end
        end
    end

    assign out_beats = r_out_beats;
`else
    logic [CNT_W-1:0] w_unused_cnt_w;
    assign w_unused_cnt_w = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_xor_checksum_accum.sv
// ============================================================================
// Module      : tb_xor_checksum_accum
// Description : Directed self-checking bench for xor_checksum_accum (WIDTH=8).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_xor_checksum_accum;

    localparam int WIDTH = 8;
    localparam int CNT_W = 16;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_checksum;
    logic             out_parity;
`ifdef XOR_ACC_BEAT_COUNT_EN
    logic [CNT_W-1:0] out_beats;
`endif

    int n_checks;
    int n_fail;

    xor_checksum_accum #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_checksum (out_checksum),
        .out_parity   (out_parity)
`ifdef XOR_ACC_BEAT_COUNT_EN
        ,
        .out_beats    (out_beats)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are sampled 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_result(input string tag, input logic [7:0] cks, input logic par);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_cks"}, 32'(out_checksum), 32'(cks));
        check({tag, "_par"}, 32'(out_parity), 32'(par));
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;

        // Reset state
        #3;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_cks", 32'(out_checksum), 32'h00);
        check("rst_par", 32'(out_parity), 32'd0);
        step();
        #2 rst_n = 1'b1;
        step();
        check("idle_valid", 32'(out_valid), 32'd0);
        check("idle_ready", 32'(in_ready), 32'd1);
        check("idle_cks", 32'(out_checksum), 32'h00);

        // 3-beat frame
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data = 8'h0F; in_last = 1'b0; step();
        check("f3_b1_valid", 32'(out_valid), 32'd0);
        in_data = 8'hF0; in_last = 1'b0; step();
        in_data = 8'h3C; in_last = 1'b1; step();
        check_result("f3", 8'hC3, 1'b0);
`ifdef XOR_ACC_BEAT_COUNT_EN
        check("f3_beats", 32'(out_beats), 32'd3);
`endif
        in_valid = 1'b0; in_last = 1'b0;
        step();
        check("f3_after_ready", 32'(in_ready), 32'd1);
        check("f3_after_valid", 32'(out_valid), 32'd0);
        check("f3_hold_cks", 32'(out_checksum), 32'hC3);

        // 1-beat frame
        in_valid = 1'b1; in_data = 8'h01; in_last = 1'b1; step();
        check_result("f1", 8'h01, 1'b1);
`ifdef XOR_ACC_BEAT_COUNT_EN
        check("f1_beats", 32'(out_beats), 32'd1);
`endif
        in_valid = 1'b0; in_last = 1'b0;
        step();
        check("f1_after_ready", 32'(in_ready), 32'd1);

        // Backpressure with a pending word held on the input
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h80; in_last = 1'b0; step();
        in_data = 8'h07; in_last = 1'b1; step();
        in_data = 8'hFF; in_last = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_result("bp_hold", 8'h87, 1'b0);
            step();
        end
        check_result("bp_end", 8'h87, 1'b0);
        out_ready = 1'b1;
        step();
        check("bp_rel_ready", 32'(in_ready), 32'd1);
        check("bp_rel_valid", 32'(out_valid), 32'd0);
        step();
        // 0xFF was taken as the first beat, so this close yields 0xFF ^ 0x0F.
        in_data = 8'h0F; in_last = 1'b1; step();
        check_result("bp_next", 8'hF0, 1'b0);
`ifdef XOR_ACC_BEAT_COUNT_EN
        check("bp_next_beats", 32'(out_beats), 32'd2);
`endif
        in_valid = 1'b0; in_last = 1'b0;
        step();

        // Async reset mid-frame
        in_valid = 1'b1; in_data = 8'h55; in_last = 1'b0; step();
        in_data = 8'h11; step();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_ready", 32'(in_ready), 32'd1);
        check("arst_cks", 32'(out_checksum), 32'h00);
        #1 rst_n = 1'b1;
        in_valid = 1'b1; in_data = 8'hAA; in_last = 1'b1; step();
        check_result("arst_new", 8'hAA, 1'b0);
`ifdef XOR_ACC_BEAT_COUNT_EN
        check("arst_beats", 32'(out_beats), 32'd1);
`endif
        in_valid = 1'b0; in_last = 1'b0;
        step();

        // Idle input data must not disturb state
        in_data = 'x; step(); step();
        check("xidle_valid", 32'(out_valid), 32'd0);
        in_valid = 1'b1; in_data = 8'h5A; in_last = 1'b1; step();
        check_result("xidle_new", 8'h5A, 1'b0);
        in_valid = 1'b0; in_last = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
